adsr_vca: RTL and testbench

Gated ADSR envelope generator and VCA that sits directly downstream of the wavetable VCO. It takes the VCO audio sample and a gate CV, runs a linear attack/decay/sustain/release state machine once per sample strobe, and multiplies the audio by the envelope. It outputs the shaped audio and the raw envelope as a CV. All sample values use the codebase scale of 4 counts per mV.

---
 rtl/adsr_pkg.sv | 17 +
 rtl/adsr_vca_gate_detect.sv | 34 +++
 rtl/adsr_vca.sv | 142 ++++++++++++++
 tb/tb_adsr_vca.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adsr_pkg.sv
// Shared types and helpers for the gated ADSR envelope / VCA block.
package adsr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } adsr_state_t;

    // Largest envelope value: the positive full scale of a W-bit signed sample.
    function automatic int env_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/adsr_vca_gate_detect.sv
// Schmitt-trigger gate detector; the threshold pair gives hysteresis on the gate CV.
module gate_detect #(
    parameter int W        = 16,
    parameter int GATE_ON  = 4000,
    parameter int GATE_OFF = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_strobe,
    input  logic signed [W-1:0] sample_in,
    output logic                gate,
    output logic                gate_rise,
    output logic                gate_fall
);

    localparam logic signed [W-1:0] ON_TH  = W'(GATE_ON);
    localparam logic signed [W-1:0] OFF_TH = W'(GATE_OFF);

    // Edge pulses are combinational so the FSM sees the new gate in the same strobe.
    assign gate_rise = sample_strobe && !gate && (sample_in > ON_TH);
    assign gate_fall = sample_strobe &&  gate && (sample_in < OFF_TH);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate <= 1'b0;
        end else if (gate_rise) begin
            gate <= 1'b1;
        end else if (gate_fall) begin
            gate <= 1'b0;
        end
    end

endmodule

// File: rtl/adsr_vca.sv
// Gated linear ADSR envelope plus VCA multiply, two-stage pipeline per sample strobe.
// Build option: ADSR_EXP_RELEASE_EN selects an exponential release instead of linear.
module adsr_vca
    import adsr_pkg::*;
#(
    parameter int W             = 16,
    parameter int ATTACK_INC    = 64,
    parameter int DECAY_INC     = 16,
    parameter int RELEASE_INC   = 8,
    parameter int RELEASE_SHIFT = 9,
    parameter int GATE_ON       = 4000,
    parameter int GATE_OFF      = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_strobe,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic                out_valid
);

    localparam int              EW        = W - 1;
    localparam logic [EW-1:0]   ENV_MAX_V = EW'(env_max(W));

    logic                gate, gate_rise, gate_fall, gate_now;
    adsr_state_t         state, state_nxt;
    logic [EW-1:0]       env, env_nxt, sus, rel_step, rel_env;
    logic [W:0]          attack_sum, sus_plus;
    logic                attack_full, decay_hit, do_attack;
    logic signed [W-1:0] audio_q;
    logic                pipe_valid;
    logic signed [2*W-1:0] product;

    gate_detect #(.W(W), .GATE_ON(GATE_ON), .GATE_OFF(GATE_OFF)) u_gate (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_strobe (sample_strobe),
        .sample_in     (sample_in1),
        .gate          (gate),
        .gate_rise     (gate_rise),
        .gate_fall     (gate_fall)
    );

    assign gate_now = gate_rise | (gate & ~gate_fall);
    assign sus      = sample_in2[W-1] ? '0 : sample_in2[W-2:0];

    // Widened by one bit so attack overshoot and the decay threshold cannot wrap.
    assign attack_sum  = {2'b00, env} + (W+1)'(ATTACK_INC);
    assign attack_full = attack_sum >= {2'b00, ENV_MAX_V};
    assign sus_plus    = {2'b00, sus} + (W+1)'(DECAY_INC);
    assign decay_hit   = {2'b00, env} <= sus_plus;

`ifdef ADSR_EXP_RELEASE_EN
    assign rel_step = (env >> RELEASE_SHIFT) + 1'b1;
`else
    assign rel_step = EW'(RELEASE_INC);
`endif
    assign rel_env = (env > rel_step) ? env - rel_step : '0;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        do_attack = 1'b0;
        if (sample_strobe) begin
            unique case (state)
                IDLE: begin
                    env_nxt   = '0;
                    do_attack = gate_now;
                end
                ATTACK: begin
                    if (!gate_now) state_nxt = RELEASE;
                    else           do_attack = 1'b1;
                end
                DECAY: begin
                    if (!gate_now) begin
                        state_nxt = RELEASE;
                    end else if (decay_hit) begin
                        env_nxt   = sus;
                        state_nxt = SUSTAIN;
                    end else begin
                        env_nxt = env - EW'(DECAY_INC);
                    end
                end
                SUSTAIN: begin
                    if (!gate_now) state_nxt = RELEASE;
                    else           env_nxt   = sus;
                end
                RELEASE: begin
                    if (gate_now) begin
                        do_attack = 1'b1;
                    end else begin
                        env_nxt = rel_env;
                        if (rel_env == '0) state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    env_nxt   = '0;
                end
            endcase
            if (do_attack) begin
                env_nxt   = attack_full ? ENV_MAX_V : EW'(attack_sum);
                state_nxt = attack_full ? DECAY : ATTACK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            env        <= '0;
            audio_q    <= '0;
            pipe_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            env        <= env_nxt;
            pipe_valid <= sample_strobe;
            if (sample_strobe) audio_q <= sample_in0;
        end
    end

    assign product = audio_q * $signed({1'b0, env});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out0 <= '0;
            sample_out1 <= '0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= pipe_valid;
            if (pipe_valid) begin
                sample_out0 <= W'(product >>> (W - 1));
                sample_out1 <= {1'b0, env};
            end
        end
    end

endmodule

// File: tb/tb_adsr_vca.sv
// Directed bench for adsr_vca: vector table plus full-envelope, retrigger and reset sequences.
module tb_adsr_vca;
    import adsr_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               sample_strobe;
    logic signed [15:0] sample_in0, sample_in1, sample_in2;
    logic signed [15:0] sample_out0, sample_out1;
    logic               out_valid;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int valid_err = 0;

    adsr_vca dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_strobe (sample_strobe),
        .sample_in0    (sample_in0),
        .sample_in1    (sample_in1),
        .sample_in2    (sample_in2),
        .sample_out0   (sample_out0),
        .sample_out1   (sample_out1),
        .out_valid     (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] in0;
        logic signed [15:0] in1;
        logic signed [15:0] in2;
        int                 exp_out0;
        int                 exp_out1;
        int                 exp_gate;
        adsr_state_t        exp_state;
    } vec_t;

    vec_t vecs [7];

`ifdef ADSR_EXP_RELEASE_EN
    localparam bit EXP_REL = 1'b1;
`else
    localparam bit EXP_REL = 1'b0;
`endif

    task automatic check(input string name, input longint actual, input longint expected);
        check_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // One strobe, then verify out_valid is low, high, low on the three following edges.
    task automatic do_strobe(input int a0, input int a1, input int a2);
        @(negedge clk);
        sample_in0    = 16'(a0);
        sample_in1    = 16'(a1);
        sample_in2    = 16'(a2);
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        if (out_valid) valid_err++;
        @(posedge clk); #1;
        if (!out_valid) valid_err++;
        @(posedge clk); #1;
        if (out_valid) valid_err++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Strobe with the given inputs until the FSM reaches target or the budget runs out.
    task automatic run_until(input adsr_state_t target, input int a1, input int a2,
                             input int budget, output int n);
        n = 0;
        do begin
            do_strobe(0, a1, a2);
            n++;
        end while (dut.state != target && n < budget);
        if (dut.state != target) $display("FAIL timeout: state %0d not reached in %0d strobes", target, budget);
    endtask

    initial begin
        int n;
        sample_strobe = 1'b0;
        sample_in0 = '0; sample_in1 = '0; sample_in2 = '0;

        vecs[0] = '{16'sd0,     16'sd0,    16'sd100, 0,   0,   0, IDLE};
        vecs[1] = '{16'sd0,     16'sd3000, 16'sd100, 0,   0,   0, IDLE};
        vecs[2] = '{16'sd1000,  16'sd4001, 16'sd100, 1,   64,  1, ATTACK};
        vecs[3] = -16'sd1000 == 0 ? vecs[3] : '{-16'sd1000, 16'sd3000, 16'sd100, -4, 128, 1, ATTACK};
        vecs[4] = '{16'sd0,     16'sd1999, 16'sd100, 0,   128, 0, RELEASE};
        vecs[5] = EXP_REL ? '{16'sd32767, 16'sd1999, 16'sd100, 126, 127, 0, RELEASE}
                          : '{16'sd32767, 16'sd1999, 16'sd100, 119, 120, 0, RELEASE};
        vecs[6] = EXP_REL ? '{16'sd0, 16'sd5000, 16'sd100, 0, 191, 1, ATTACK}
                          : '{16'sd0, 16'sd5000, 16'sd100, 0, 184, 1, ATTACK};

        // Reset held with strobes toggling and a high gate present.
        rst_n = 1'b0;
        sample_in1 = 16'sd8000;
        sample_in0 = 16'sd1234;
        repeat (4) begin
            @(negedge clk); sample_strobe = 1'b1;
            @(negedge clk); sample_strobe = 1'b0;
        end
        #1;
        check("rst_out0", sample_out0, 0);
        check("rst_out1", sample_out1, 0);
        check("rst_valid", out_valid, 0);
        check("rst_state", int'(dut.state), int'(IDLE));
        check("rst_gate", dut.u_gate.gate, 0);
        @(negedge clk); rst_n = 1'b1;
        do_strobe(0, 0, 0);
        do_strobe(0, 0, 0);
        check("post_rst_env", sample_out1, 0);
        check("post_rst_state", int'(dut.state), int'(IDLE));

        // Vector table: hysteresis, first attack steps, fall, release, retrigger.
        for (int i = 0; i < 7; i++) begin
            do_strobe(vecs[i].in0, vecs[i].in1, vecs[i].in2);
            check($sformatf("vec%0d_out0", i), sample_out0, vecs[i].exp_out0);
            check($sformatf("vec%0d_out1", i), sample_out1, vecs[i].exp_out1);
            check($sformatf("vec%0d_gate", i), dut.u_gate.gate, vecs[i].exp_gate);
            check($sformatf("vec%0d_state", i), int'(dut.state), int'(vecs[i].exp_state));
        end

        // Full envelope with sus = 8000 and VCA spot checks along the attack.
        apply_reset();
        n = 0;
        do begin
            do_strobe((n == 255) ? 20000 : (n == 511) ? -32768 : 0, 8000, 8000);
            n++;
            if (n == 256) begin
                check("vca_half_env", sample_out1, 16384);
                check("vca_half_out", sample_out0, 10000);
            end
        end while (dut.state != DECAY && n < 2000);
        check("attack_strobes", n, 512);
        check("attack_env_max", sample_out1, 32767);
        check("vca_full_neg", sample_out0, -32767);
        run_until(SUSTAIN, 8000, 8000, 3000, n);
        check("decay_strobes", n, 1548);
        check("decay_sus_env", sample_out1, 8000);
        do_strobe(0, 8000, 9000);
        check("sus_track_up", sample_out1, 9000);
        do_strobe(0, 8000, -5);
        check("sus_negative", sample_out1, 0);
        do_strobe(0, 8000, 8000);
        check("sus_back", sample_out1, 8000);
        do_strobe(0, 0, 8000);
        check("fall_state", int'(dut.state), int'(RELEASE));
        check("fall_env_kept", sample_out1, 8000);
        run_until(IDLE, 0, 8000, 6000, n);
        if (!EXP_REL) check("release_strobes", n, 1000);
        check("release_env_zero", sample_out1, 0);

        // Retrigger from RELEASE at env = 10000: attack continues from there.
        run_until(SUSTAIN, 8000, 10000, 3000, n);
        check("retrig_sus", sample_out1, 10000);
        do_strobe(0, 0, 10000);
        check("retrig_rel_env", sample_out1, 10000);
        do_strobe(0, 8000, 10000);
        check("retrig_state", int'(dut.state), int'(ATTACK));
        check("retrig_env", sample_out1, 10064);
        do_strobe(0, 0, 10000);
        check("attack_fall_env", sample_out1, 10064);
        do_strobe(0, 0, 10000);
        check("retrig_rel_step", sample_out1, EXP_REL ? 10044 : 10056);
        run_until(IDLE, 0, 10000, 6000, n);
        check("retrig_idle_env", sample_out1, 0);

        // Release from ENV_MAX.
        apply_reset();
        run_until(DECAY, 8000, 8000, 2000, n);
        do_strobe(0, 0, 8000);
        check("max_fall_env", sample_out1, 32767);
        do_strobe(0, 0, 8000);
        check("max_rel_first", sample_out1, EXP_REL ? 32703 : 32759);
        run_until(IDLE, 0, 8000, 6000, n);
        check("max_rel_idle", int'(dut.state), int'(IDLE));
        check("max_rel_zero", sample_out1, 0);

        // Reset between stage 1 and stage 2 drops the in-flight sample.
        @(negedge clk);
        sample_in1 = 16'sd8000;
        sample_in0 = 16'sd1000;
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_out1", sample_out1, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid_after", out_valid, 0);

        check("valid_pulse_errors", valid_err, 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
